seq_mag_comparator: RTL
=======================

# seq_mag_comparator

Parametrised, multi-cycle successor to the team's 4-bit cascadable magnitude comparator. It accepts two DATA_W-bit operands and three cascade inputs over a valid/ready handshake, and compares them MSB-first, one CHUNK_W slice per clock, stopping at the first differing slice. It returns registered eq/lt/gt flags over a second valid/ready handshake. It sits between operand producers and sort/threshold logic that needs wide compares without a wide combinational path.

## Interface

- `DATA_W`, 32: operand width. Must be a multiple of CHUNK_W; elaboration error otherwise.
- `CHUNK_W`, 4: slice width compared per cycle; ≥1.
- Derived constant `NCHUNK = DATA_W/CHUNK_W`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept (IDLE only).
- `a`, `b`  in  DATA_W  operands.
- `signed_mode`  in  1  1 = two's-complement compare, 0 = unsigned; sampled at accept.
- `casc_eq`, `casc_lt`, `casc_gt`  in  1 each  cascade inputs from a less-significant stage; sampled at accept.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_eq`, `out_lt`, `out_gt`  out  1 each  result flags.
- `out_nchk`  out  $clog2(NCHUNK+1)  number of slices examined (1..NCHUNK).

## Operation

- States: IDLE, CMP, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register a, b, signed_mode and the cascade inputs, set idx=NCHUNK-1, go to CMP.
- CMP: each cycle compare slice idx of a vs b, unsigned. In signed mode, invert bit DATA_W-1 of both operands in slice NCHUNK-1 before comparing.
  - Slices differ: out_lt/out_gt from the slice compare, out_eq=0, go to DONE.
  - Slices equal and idx==0: out_eq=casc_eq, out_lt=casc_lt, out_gt=casc_gt, go to DONE.
  - Otherwise idx decrements and the block stays in CMP.
  - out_nchk = NCHUNK-idx at the deciding cycle.
- Cascade values pass through with no one-hot check, so several flags may assert together; this matches the 4-bit part's cascade semantics.
- DONE: out_valid=1 and outputs held stable until out_ready; on out_valid&&out_ready go to IDLE.
- in_ready=0 in CMP and DONE; in_valid there is ignored and does not corrupt the active compare.
- No combinational path from inputs to outputs.

## Timing

- Reset: state=IDLE, in_ready=1, out_valid=0, out_eq=out_lt=out_gt=0, out_nchk=0, idx=0.
- Reset asserted mid-CMP or mid-DONE aborts immediately. The pending result is lost and never presented.
- Latency: accept edge E0. The first slice decision occurs at edge E1, and out_valid rises after edge Em, where m = out_nchk (1 ≤ m ≤ NCHUNK).
- Worst case: NCHUNK cycles accept-to-valid (equal operands).
- Throughput: one compare per m+2 cycles minimum (accept, m compares, handshake back to IDLE). No accept in the same cycle as out handshake.
- out_ready held low: DONE persists indefinitely with outputs unchanged.
- NCHUNK=1: every compare takes exactly one CMP cycle.

## Structure

- Package `mag_cmp_pkg`:
  - state enum typedef (IDLE/CMP/DONE);
  - packed struct `mag_cmp_res_t` {eq, lt, gt};
  - function computing NCHUNK and the out_nchk width.
- Sub-module `mag_cmp_slice`: combinational CHUNK_W compare producing {eq, lt, gt}, parametrised on CHUNK_W, instantiated once and fed by an idx-indexed mux. Sign-bit inversion is applied outside the slice.
- Top-level holds the FSM, operand/cascade registers, idx counter and result registers.

## Test plan

- Unsigned, defaults: a=0x8000_0000, b=0x7FFF_FFFF, cascade 000 -> out_gt=1, out_lt=0, out_eq=0, out_nchk=1, out_valid one cycle after accept.
- Equal operands: a=b=0x1234_5678, cascade eq=1 lt=0 gt=0 -> out_eq=1, out_nchk=8, out_valid 8 cycles after accept. Repeat with cascade lt=1 gt=1 eq=0 -> out_lt=1, out_gt=1, out_eq=0.
- Signed: signed_mode=1, a=0xFFFF_FFFF (-1), b=0x0000_0001 -> out_lt=1. Same operands unsigned -> out_gt=1.
- Early termination at LSB slice: a=0x0000_0005, b=0x0000_0003 -> out_gt=1, out_nchk=8. a=0x0000_0050, b=0x0000_0030 -> out_nchk=7.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands -> outputs stable, in_ready=0, no second accept. Raise out_ready -> IDLE next cycle, new accept follows.
- Reset mid-CMP: assert rst during the 3rd CMP cycle of an equal-operand compare -> out_valid=0 and in_ready=1 immediately. After release, a fresh compare of a=3, b=3 (cascade eq=1) yields out_eq=1.

Source files
------------

// File: rtl/mag_cmp_pkg.sv
// mag_cmp_pkg: shared types and sizing helpers for the sequential magnitude
// comparator.
//   state_e        - FSM states (idle / compare / done)
//   mag_cmp_res_t  - packed {eq, lt, gt} result flags
//   calc_nchunk    - number of CHUNK_W slices in a DATA_W operand
//   calc_nchk_w    - width of the slice-count output (holds 0..NCHUNK)
package mag_cmp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StDone
  } state_e;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } mag_cmp_res_t;

  function automatic int unsigned calc_nchunk(int unsigned data_w, int unsigned chunk_w);
    return data_w / chunk_w;
  endfunction

  function automatic int unsigned calc_nchk_w(int unsigned data_w, int unsigned chunk_w);
    return $clog2(calc_nchunk(data_w, chunk_w) + 1);
  endfunction

endpackage

// File: rtl/mag_cmp_slice.sv
// mag_cmp_slice: combinational unsigned compare of one CHUNK_W-bit slice.
//   a, b - slice operands (any sign handling is done by the caller)
//   res  - {eq, lt, gt}, exactly one flag set
module mag_cmp_slice
  import mag_cmp_pkg::*;
#(
  parameter int unsigned CHUNK_W = 4
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  output mag_cmp_res_t       res
);

  always_comb begin
    res    = '0;
    res.eq = (a == b);
    res.lt = (a < b);
    res.gt = (a > b);
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: multi-cycle DATA_W-bit magnitude comparator. Operands are
// compared MSB-first, one CHUNK_W slice per clock, stopping at the first
// differing slice; equal operands fall through to the cascade inputs.
//   clk, rst                      - clock, async active-high reset
//   in_valid/in_ready             - operand handshake (ready only when idle)
//   a, b                          - operands
//   signed_mode                   - 1: two's-complement compare, 0: unsigned
//   casc_eq/casc_lt/casc_gt       - cascade inputs from a less-significant stage
//   out_valid/out_ready           - result handshake
//   out_eq/out_lt/out_gt          - registered result flags
//   out_nchk                      - slices examined to reach the decision
module seq_mag_comparator
  import mag_cmp_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CHUNK_W = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [DATA_W-1:0]                          a,
  input  logic [DATA_W-1:0]                          b,
  input  logic                                       signed_mode,
  input  logic                                       casc_eq,
  input  logic                                       casc_lt,
  input  logic                                       casc_gt,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       out_eq,
  output logic                                       out_lt,
  output logic                                       out_gt,
  output logic [calc_nchk_w(DATA_W, CHUNK_W)-1:0]    out_nchk
);

  localparam int unsigned NCHUNK = calc_nchunk(DATA_W, CHUNK_W);
  localparam int unsigned NCHK_W = calc_nchk_w(DATA_W, CHUNK_W);
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK_W < 1) || ((DATA_W % CHUNK_W) != 0)) begin : g_bad_width
    $error("DATA_W must be a non-zero multiple of CHUNK_W");
  end

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                signed_q, signed_d;
  mag_cmp_res_t        casc_q, casc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  mag_cmp_res_t        res_q, res_d;
  logic [NCHK_W-1:0]   nchk_q, nchk_d;

  logic [DATA_W-1:0]   a_eff, b_eff;
  logic [CHUNK_W-1:0]  sl_a, sl_b;
  mag_cmp_res_t        sl_res;

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned slice comparator serves both modes.
  always_comb begin
    a_eff             = a_q;
    b_eff             = b_q;
    a_eff[DATA_W-1]   = a_q[DATA_W-1] ^ signed_q;
    b_eff[DATA_W-1]   = b_q[DATA_W-1] ^ signed_q;
  end

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sl_a = a_eff[i*CHUNK_W +: CHUNK_W];
        sl_b = b_eff[i*CHUNK_W +: CHUNK_W];
      end
    end
  end

  mag_cmp_slice #(
    .CHUNK_W (CHUNK_W)
  ) u_slice (
    .a   (sl_a),
    .b   (sl_b),
    .res (sl_res)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    casc_d   = casc_q;
    idx_d    = idx_q;
    res_d    = res_q;
    nchk_d   = nchk_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          signed_d = signed_mode;
          casc_d   = '{eq: casc_eq, lt: casc_lt, gt: casc_gt};
          idx_d    = IDX_W'(NCHUNK - 1);
          state_d  = StCmp;
        end
      end
      StCmp: begin
        if (!sl_res.eq) begin
          res_d   = '{eq: 1'b0, lt: sl_res.lt, gt: sl_res.gt};
          nchk_d  = NCHK_W'(NCHUNK) - NCHK_W'(idx_q);
          state_d = StDone;
        end else if (idx_q == '0) begin
          // Cascade flags pass through unchecked; several may be set at once.
          res_d   = casc_q;
          nchk_d  = NCHK_W'(NCHUNK);
          state_d = StDone;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      casc_q   <= '0;
      idx_q    <= '0;
      res_q    <= '0;
      nchk_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      casc_q   <= casc_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      nchk_q   <= nchk_d;
    end
  end

  // Handshake outputs decode straight from the state register.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_eq    = res_q.eq;
  assign out_lt    = res_q.lt;
  assign out_gt    = res_q.gt;
  assign out_nchk  = nchk_q;

endmodule
